// File: rtl/ga_issue_ctrl_if.sv
// Core-side, coprocessor-side and writeback signals of the GA issue controller.
// master = the issue controller, slave = the core/coprocessor environment.
interface ga_issue_ctrl_if;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [3:0]  core_funct_i;
  logic [4:0]  core_rd_i;
  logic [31:0] core_op_a_i;
  logic [31:0] core_op_b_i;

  logic        ga_req_valid_o;
  logic [3:0]  ga_funct_o;
  logic [31:0] ga_op_a_o;
  logic [31:0] ga_op_b_o;
  logic [4:0]  ga_rd_o;
  logic        ga_busy_i;
  logic        ga_resp_valid_i;
  logic [31:0] ga_resp_result_i;
  logic        ga_resp_error_i;

  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_error_o;
  logic        wb_ready_i;
  logic        flush_i;

  modport master (
    input  core_valid_i, core_funct_i, core_rd_i, core_op_a_i, core_op_b_i,
    input  ga_busy_i, ga_resp_valid_i, ga_resp_result_i, ga_resp_error_i,
    input  wb_ready_i, flush_i,
    output core_ready_o,
    output ga_req_valid_o, ga_funct_o, ga_op_a_o, ga_op_b_o, ga_rd_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_error_o
  );

  modport slave (
    output core_valid_i, core_funct_i, core_rd_i, core_op_a_i, core_op_b_i,
    output ga_busy_i, ga_resp_valid_i, ga_resp_result_i, ga_resp_error_i,
    output wb_ready_i, flush_i,
    input  core_ready_o,
    input  ga_req_valid_o, ga_funct_o, ga_op_a_o, ga_op_b_o, ga_rd_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_error_o
  );
endinterface

// File: rtl/ga_issue_ctrl.sv
// Single-outstanding GA instruction issue: accept -> request -> response/timeout -> writeback.
// Latency accept-to-wb_valid 3 cycles min; busy stalls ISSUE, wb_ready_i low holds WB, flush abandons.
module ga_issue_ctrl #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  ga_issue_ctrl_if.master io
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4
  } state_e;

  localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        core_ready_q, core_ready_d;
  logic [3:0]  funct_q, funct_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_err_q, wb_err_d;
  logic        req_vld;
  logic        accept;
  logic        timeout;

  assign accept  = (state_q == IDLE) && core_ready_q && io.core_valid_i && !io.flush_i;
  assign timeout = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct_d   = funct_q;
    rd_d      = rd_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    req_vld   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct_d = io.core_funct_i;
          rd_d    = io.core_rd_i;
          op_a_d  = io.core_op_a_i;
          op_b_d  = io.core_op_b_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (io.flush_i) begin
          state_d = IDLE;
        end else if (!io.ga_busy_i) begin
          req_vld = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A flush coinciding with the ending event has nothing left to drain.
        if (io.flush_i) begin
          if (io.ga_resp_valid_i || timeout) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = DRAIN;
          end
        end else if (io.ga_resp_valid_i) begin
          wb_data_d = io.ga_resp_result_i;
          wb_err_d  = io.ga_resp_error_i;
          state_d   = WB;
        end else if (timeout) begin
          wb_data_d = 32'd0;
          wb_err_d  = 1'b1;
          state_d   = WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (io.ga_resp_valid_i || timeout) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        if (io.flush_i || io.wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    core_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      core_ready_q <= 1'b0;
      funct_q      <= 4'd0;
      rd_q         <= 5'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      wb_data_q    <= 32'd0;
      wb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_ready_q <= core_ready_d;
      funct_q      <= funct_d;
      rd_q         <= rd_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      wb_data_q    <= wb_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign io.core_ready_o   = core_ready_q;
  assign io.ga_req_valid_o = req_vld;
  assign io.ga_funct_o     = funct_q;
  assign io.ga_op_a_o      = op_a_q;
  assign io.ga_op_b_o      = op_b_q;
  assign io.ga_rd_o        = rd_q;
  assign io.wb_valid_o     = (state_q == WB);
  assign io.wb_rd_o        = rd_q;
  assign io.wb_data_o      = wb_data_q;
  assign io.wb_error_o     = wb_err_q;

endmodule

// File: tb/tb_ga_issue_ctrl.sv
// Bench for ga_issue_ctrl: directed and random transactions against a cycle-schedule model.
module tb_ga_issue_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ga_issue_ctrl_if bus ();

  ga_issue_ctrl #(.TimeoutCycles(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.core_valid_i     = 1'b0;
    bus.core_funct_i     = 4'd0;
    bus.core_rd_i        = 5'd0;
    bus.core_op_a_i      = 32'd0;
    bus.core_op_b_i      = 32'd0;
    bus.ga_busy_i        = 1'b0;
    bus.ga_resp_valid_i  = 1'b0;
    bus.ga_resp_result_i = 32'd0;
    bus.ga_resp_error_i  = 1'b0;
    bus.wb_ready_i       = 1'b0;
    bus.flush_i          = 1'b0;
  endtask

  // Cycle 0 presents the instruction; cycle c is c cycles after the accepting edge.
  // B busy cycles, fi flush index inside ISSUE, R response index in WAIT, F flush
  // index in WAIT, S wb_ready stall cycles, fw flush index in WB, blk flush-blocked attempt.
  task automatic run_txn(input logic [3:0] f, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rdata, input logic rerr,
                         input int B, input int fi, input int R, input int F,
                         input int S, input int fw, input bit blk);
    bit iflush, rvalid, has_wb;
    int req_c, wait0, kend, endc, wb_first, wb_last, ready_c, last;
    logic [31:0] exp_data;
    logic        exp_err;
    iflush = (fi >= 0) && (fi <= B);
    rvalid = (R >= 0) && (R <= TO - 1);
    req_c  = B + 1;
    wait0  = B + 2;
    kend   = rvalid ? R : TO - 1;
    endc   = wait0 + kend;
    if (iflush || F > kend) F = -1;
    has_wb   = !iflush && (F < 0);
    exp_data = rvalid ? rdata : 32'd0;
    exp_err  = rvalid ? rerr : 1'b1;
    if (!has_wb || fw > S) fw = -1;
    wb_first = endc + 1;
    wb_last  = (fw >= 0) ? wb_first + fw : wb_first + S;
    if (iflush)      ready_c = fi + 2;
    else if (has_wb) ready_c = wb_last + 1;
    else             ready_c = endc + 1;
    last = ready_c;
    if (R >= 0 && wait0 + R > last) last = wait0 + R;

    if (blk) begin
      idle_inputs();
      bus.core_valid_i = 1'b1;
      bus.core_funct_i = f;
      bus.flush_i      = 1'b1;
      @(negedge clk);
      chk("blk_ready", 96'(bus.core_ready_o), 96'd1);
      @(posedge clk); #1;
    end

    for (int c = 0; c <= last; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.core_valid_i = 1'b1;
        bus.core_funct_i = f;
        bus.core_rd_i    = rd;
        bus.core_op_a_i  = a;
        bus.core_op_b_i  = b;
      end else begin
        bus.core_funct_i = 4'($urandom);
        bus.core_rd_i    = 5'($urandom);
        bus.core_op_a_i  = $urandom;
        bus.core_op_b_i  = $urandom;
      end
      bus.ga_busy_i = (c >= 1) && (c <= B);
      if (R >= 0 && c == wait0 + R) begin
        bus.ga_resp_valid_i  = 1'b1;
        bus.ga_resp_result_i = rdata;
        bus.ga_resp_error_i  = rerr;
      end
      bus.flush_i = (iflush && c == 1 + fi) || (F >= 0 && c == wait0 + F) ||
                    (fw >= 0 && c == wb_first + fw);
      bus.wb_ready_i = (c >= wb_first + S);

      @(negedge clk);
      chk($sformatf("core_ready c%0d", c), 96'(bus.core_ready_o),
          96'((c == 0) || (c >= ready_c)));
      chk($sformatf("req_vld c%0d", c), 96'(bus.ga_req_valid_o),
          96'(!iflush && c == req_c));
      chk($sformatf("wb_vld c%0d", c), 96'(bus.wb_valid_o),
          96'(has_wb && c >= wb_first && c <= wb_last));
      if (c >= 1)
        chk($sformatf("ga_fields c%0d", c),
            {23'd0, bus.ga_funct_o, bus.ga_rd_o, bus.ga_op_a_o, bus.ga_op_b_o},
            {23'd0, f, rd, a, b});
      if (has_wb && c >= wb_first && c <= wb_last)
        chk($sformatf("wb_dat c%0d", c),
            {58'd0, bus.wb_rd_o, bus.wb_error_o, bus.wb_data_o},
            {58'd0, rd, exp_err, exp_data});
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctl"}, {93'd0, bus.core_ready_o, bus.ga_req_valid_o, bus.wb_valid_o}, 96'd0);
    chk({tag, " ga"}, {23'd0, bus.ga_funct_o, bus.ga_rd_o, bus.ga_op_a_o, bus.ga_op_b_o}, 96'd0);
    chk({tag, " wb"}, {58'd0, bus.wb_rd_o, bus.wb_error_o, bus.wb_data_o}, 96'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rise", 96'(bus.core_ready_o), 96'd1);

    // f, rd, a, b, rdata, rerr, B, fi, R, F, S, fw, blk
    run_txn(4'd3, 5'd7, 32'h10, 32'h20, 32'h30, 1'b0, 0, -1, 0, -1, 0, -1, 1'b0);
    run_txn(4'd5, 5'd2, 32'h1, 32'h2, 32'h55, 1'b0, 5, -1, 1, -1, 0, -1, 1'b0);
    run_txn(4'd1, 5'd3, 32'hA, 32'hB, 32'hBEEF, 1'b0, 0, -1, -1, -1, 0, -1, 1'b0);
    run_txn(4'd2, 5'd4, 32'hC, 32'hD, 32'h1234, 1'b0, 0, -1, TO - 1, -1, 0, -1, 1'b0);
    run_txn(4'd6, 5'd9, 32'hE, 32'hF, 32'h777, 1'b0, 0, -1, TO, -1, 0, -1, 1'b0);
    run_txn(4'd7, 5'd11, 32'h3, 32'h4, 32'hBAD, 1'b1, 1, -1, 3, -1, 1, -1, 1'b0);
    run_txn(4'd8, 5'd12, 32'h5, 32'h6, 32'h99, 1'b0, 0, -1, 4, 1, 0, -1, 1'b0);
    run_txn(4'd9, 5'd13, 32'h7, 32'h8, 32'hCAFE, 1'b0, 0, -1, 0, -1, 0, -1, 1'b0);
    run_txn(4'd10, 5'd14, 32'h9, 32'h1, 32'h42, 1'b0, 0, -1, 2, -1, 4, -1, 1'b0);
    run_txn(4'd11, 5'd15, 32'h2, 32'h3, 32'h43, 1'b0, 0, 0, 1, -1, 0, -1, 1'b0);
    run_txn(4'd12, 5'd16, 32'h4, 32'h5, 32'h44, 1'b0, 2, 2, 1, -1, 0, -1, 1'b0);
    run_txn(4'd13, 5'd17, 32'h6, 32'h7, 32'h45, 1'b0, 0, -1, 1, -1, 4, 2, 1'b0);
    run_txn(4'd14, 5'd18, 32'h8, 32'h9, 32'h46, 1'b0, 0, -1, 0, -1, 0, -1, 1'b1);

    // Reset pulse while waiting for a response, then a stale response after release.
    idle_inputs();
    bus.core_valid_i = 1'b1;
    bus.core_funct_i = 4'd15;
    bus.core_rd_i    = 5'd20;
    bus.core_op_a_i  = 32'h11;
    bus.core_op_b_i  = 32'h22;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.ga_resp_valid_i  = 1'b1;
    bus.ga_resp_result_i = 32'hDEAD;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_ready", 96'(bus.core_ready_o), 96'd1);
    chk("post_rst_wb", 96'(bus.wb_valid_o), 96'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_wb2", 96'(bus.wb_valid_o), 96'd0);
    chk("post_rst_req", 96'(bus.ga_req_valid_o), 96'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      int B, fi, R, F, S, fw, sel, gap;
      bit blk;
      B   = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       R = -1;
        1:       R = TO - 1;
        2:       R = TO + int'($urandom_range(0, 3));
        default: R = int'($urandom_range(0, 6));
      endcase
      F   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      S   = int'($urandom_range(0, 3));
      fw  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      fi  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, B)) : -1;
      blk = ($urandom_range(0, 7) == 0);
      run_txn(4'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
              1'($urandom), B, fi, R, F, S, fw, blk);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bus.ga_resp_valid_i  = 1'($urandom);
        bus.ga_resp_result_i = $urandom;
        @(negedge clk);
        chk("gap_ready", 96'(bus.core_ready_o), 96'd1);
        chk("gap_wb", 96'(bus.wb_valid_o), 96'd0);
        @(posedge clk); #1;
      end
      idle_inputs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ga_issue_ctrl.md
GA_ISSUE_CTRL -- requirements
Module: ga_issue_ctrl

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 16, the number of WAIT cycles without a response before a timeout is declared; legal range 2..255.
REQ-002 SHALL have port clk_i  in  1  the single clock; all flops rise-edge triggered.
REQ-003 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port core_valid_i  in  1  core presents a decoded GA instruction.
REQ-005 SHALL have port core_ready_o  out  1  block accepts an instruction.
REQ-006 SHALL have port core_funct_i  in  4  GA function code.
REQ-007 SHALL have port core_rd_i  in  5  destination register.
REQ-008 SHALL have port core_op_a_i  in  32  operand A.
REQ-009 SHALL have port core_op_b_i  in  32  operand B.
REQ-010 SHALL have port ga_req_valid_o  out  1  single-cycle request strobe to the coprocessor.
REQ-011 SHALL have port ga_funct_o  out  4  captured function code.
REQ-012 SHALL have port ga_op_a_o  out  32  captured operand A.
REQ-013 SHALL have port ga_op_b_o  out  32  captured operand B.
REQ-014 SHALL have port ga_rd_o  out  5  captured destination.
REQ-015 SHALL have port ga_busy_i  in  1  coprocessor cannot take a request.
REQ-016 SHALL have port ga_resp_valid_i  in  1  coprocessor result strobe.
REQ-017 SHALL have port ga_resp_result_i  in  32  coprocessor result.
REQ-018 SHALL have port ga_resp_error_i  in  1  coprocessor error flag.
REQ-019 SHALL have port wb_valid_o  out  1  writeback to the core is pending.
REQ-020 SHALL have port wb_rd_o  out  5  writeback destination.
REQ-021 SHALL have port wb_data_o  out  32  writeback data.
REQ-022 SHALL have port wb_error_o  out  1  coprocessor error or timeout.
REQ-023 SHALL have port wb_ready_i  in  1  core accepts the writeback.
REQ-024 SHALL have port flush_i  in  1  core pipeline flush; discard the in-flight instruction.

Function
REQ-025 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DRAIN and WB; at most one instruction is in flight.
REQ-026 SHALL drive core_ready_o from a register, 1 only in IDLE; on core_valid_i&&core_ready_o it SHALL capture funct/rd/op_a/op_b and go to ISSUE.
REQ-027 ISSUE: SHALL assert ga_req_valid_o for exactly one cycle in the first ISSUE cycle with ga_busy_i=0, then go to WAIT with the timeout counter at 0; while ga_busy_i=1 SHALL hold ISSUE with ga_req_valid_o=0.
REQ-028 SHALL hold ga_funct_o/ga_op_a_o/ga_op_b_o/ga_rd_o stable from capture until the next accept.
REQ-029 WAIT: counter increments by 1 per cycle; on ga_resp_valid_i SHALL register result and error and go to WB.
REQ-030 WAIT: when the counter equals TimeoutCycles-1 and no response is present, SHALL go to WB with wb_data_o=0 and wb_error_o=1.
REQ-031 A response arriving in the timeout cycle SHALL win: the real result is written back with its own error flag.
REQ-032 SHALL ignore ga_resp_valid_i in IDLE, ISSUE and WB; a stale late response SHALL NOT produce a writeback.
REQ-033 WB: SHALL hold wb_valid_o=1 with stable wb_rd_o/wb_data_o/wb_error_o until wb_ready_i=1, then go to IDLE.
REQ-034 Minimum latency: accept at edge N, ga_req_valid_o high in cycle N+1, response in cycle N+2, wb_valid_o high in cycle N+3.
REQ-035 flush_i in IDLE SHALL block the accept, even with core_valid_i=1; in ISSUE it SHALL return to IDLE with no request issued.
REQ-036 flush_i in WAIT SHALL go to DRAIN; DRAIN SHALL return to IDLE on a response or timeout without raising wb_valid_o.
REQ-037 flush_i in WB SHALL drop wb_valid_o next cycle and go to IDLE; flush_i in DRAIN has no further effect.

Reset
REQ-038 While rst_ni=0: state=IDLE, counter=0, every output 0 (including core_ready_o), captured fields 0.
REQ-039 core_ready_o SHALL rise at the first clk_i edge after rst_ni deasserts; reset mid-operation SHALL abandon the instruction with no writeback.

Verification
REQ-040 Accept funct=3, rd=7, a=0x10, b=0x20; response 0x30 two cycles later; wb_ready_i=1 -> ga_req_valid_o one cycle, wb_valid_o with rd=7, data=0x30, error=0.
REQ-041 ga_busy_i=1 for 5 cycles after accept -> ga_req_valid_o held 0, pulses once in the cycle after busy drops.
REQ-042 TimeoutCycles=16, no response -> wb_valid_o with data=0, error=1 after 16 WAIT cycles; response in the 16th WAIT cycle -> real data returned, error=0.
REQ-043 flush_i in the 2nd WAIT cycle, response 3 cycles later -> no wb_valid_o; core_ready_o returns to 1; the next instruction completes normally.
REQ-044 wb_ready_i=0 for 4 cycles -> wb outputs stable and core_ready_o=0 throughout; rst_ni pulse in WAIT -> all outputs 0 with no writeback.
